cdc_arith_hs: RTL and testbench
===============================

// Module: cdc_arith_hs
// PURPOSE
//  Two-clock arithmetic unit with full req/ack toggle handshake. Operands and mode are captured in the
//  clk_1 (source) domain and handed to the clk_2 (dest) domain via a synchronised request toggle.
//  Result is presented in clk_2 with valid/ready back-pressure; an ack toggle returns to clk_1 to
//  re-open the input. Generalises the single-shot add/mul CDC block: width, sync depth, 4 modes.
// PARAMETERS
//  W            4   operand width in bits (in_a, in_b)
//  SYNC_STAGES  2   flops per bit synchroniser (>=2), both directions
//  OUT_W        2*W result width (derived localparam, not overridable)
// PORTS
//  clk_1      in   1      source clock; rising edge
//  clk_2      in   1      dest clock; rising edge, unrelated to clk_1
//  rst_n      in   1      reset, asynchronous, active-low, common to both domains
//  in_valid   in   1      clk_1: operand offer
//  in_ready   out  1      clk_1: block can accept; transfer when in_valid && in_ready
//  in_a       in   W      clk_1: operand A (unsigned)
//  in_b       in   W      clk_1: operand B (unsigned)
//  mode       in   2      clk_1: 0 ADD, 1 SUB, 2 MUL, 3 MAX
//  in_drop    out  1      clk_1: sticky; set when in_valid && !in_ready
//  out_valid  out  1      clk_2: result valid
//  out_ready  in   1      clk_2: consumer accepts; transfer when out_valid && out_ready
//  out        out  OUT_W  clk_2: result; 0 whenever out_valid==0
// BEHAVIOUR
//  Reset (async, both domains): in_ready=1, in_drop=0, out_valid=0, out=0, req/ack toggles=0,
//   hold regs=0, dest FSM=IDLE. Outputs take reset values immediately on rst_n low, mid-transfer too.
//  Source: on accept at clk_1 edge k: hold regs <- {in_a,in_b,mode}, req_tgl flips, in_ready=0.
//   Hold regs stay unchanged until the ack returns (multi-bit data never sampled while changing).
//   ack_tgl synchronised into clk_1 (SYNC_STAGES) then edge-detected vs. a delay flop;
//   on detection in_ready=1 next clk_1 edge. One transaction in flight, max.
//  in_valid while in_ready=0: ignored, in_drop<=1 (cleared only by reset).
//  Dest FSM (clk_2): IDLE -> COMP when synced req_tgl != its delay flop;
//   COMP -> OUT unconditionally, out register loaded from hold regs;
//   OUT: out_valid=1, out held stable; if out_ready: ack_tgl flips, -> IDLE next edge.
//   OUT with out_ready=0: stay, no change to out. Unused encoding -> IDLE.
//  Arithmetic (operands zero-extended to OUT_W):
//   ADD a+b; SUB a-b two's complement mod 2^OUT_W; MUL a*b; MAX a>=b ? a : b.
//  Latency: accept -> out_valid = SYNC_STAGES+3 clk_2 edges (+ up to 1 for phase);
//   out handshake -> in_ready = SYNC_STAGES+2 clk_1 edges (+ up to 1).
//  Toggle (2-phase) signalling: edge detectors must not fire on reset release (delay flops reset 0).
// STRUCTURE
//  Package cdc_arith_pkg: typedef enum logic[1:0] mode_e {ADD,SUB,MUL,MAX};
//   typedef enum logic[1:0] dst_state_e {IDLE,COMP,OUT}.
//  Sub-module cdc_sync_bit #(STAGES): 1-bit N-flop synchroniser, async reset to 0; instantiated
//   twice (req into clk_2, ack into clk_1). No other logic crosses domains except stable hold regs.
// TESTING (clk_1 10ns, clk_2 17ns unless stated; W=4, SYNC_STAGES=2)
//  Reset: rst_n low 3 cycles -> in_ready=1, out_valid=0, out=0, in_drop=0.
//  ADD a=F b=F, out_ready=1 -> single out_valid pulse, out=8'h1E; in_ready returns to 1.
//  SUB a=3 b=5 -> out=8'hFE; MUL a=F b=F -> out=8'hE1; MAX a=9 b=C -> out=8'h0C.
//  Back-pressure: out_ready=0 for 10 clk_2 cycles -> out_valid and out constant, in_ready stays 0;
//   release -> exactly one transfer, then in_ready=1.
//  Drop: second in_valid while in_ready=0 -> in_drop=1, only first result appears, no extra out_valid.
//  Clock ratio sweep (clk_2 3ns and 47ns), 200 random back-to-back ops with random out_ready ->
//   scoreboard exact match, in order, no loss; plus rst_n mid-OUT -> all outputs to reset values.

Source files
------------

// File: rtl/cdc_arith_pkg.sv
// Shared types for the two-clock arithmetic handshake block.
`timescale 1ns/1ps
package cdc_arith_pkg;

    typedef enum logic [1:0] {
        ModeAdd = 2'd0,
        ModeSub = 2'd1,
        ModeMul = 2'd2,
        ModeMax = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StComp = 2'd1,
        StOut  = 2'd2
    } dst_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset to 0.
`timescale 1ns/1ps
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_arith_hs.sv
// Two-clock arithmetic unit: operands captured in clk_1, result delivered in clk_2,
// with a 2-phase req/ack toggle handshake keeping one transaction in flight.
`timescale 1ns/1ps
module cdc_arith_hs
    import cdc_arith_pkg::*;
#(
    parameter int unsigned W           = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk_1,
    input  logic           clk_2,
    input  logic           rst_n,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   in_a_i,
    input  logic [W-1:0]   in_b_i,
    input  logic [1:0]     mode_i,
    output logic           in_drop_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*W-1:0] out_o
);

    localparam int unsigned OUT_W = 2 * W;

    // ---------------- source domain (clk_1) ----------------
    logic       in_ready_q, in_ready_d, in_drop_q, in_drop_d;
    logic       req_tgl_q, req_tgl_d, ack_dly_q, ack_sync;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    mode_e      mode_q, mode_d;

    always_comb begin
        in_ready_d = in_ready_q;
        in_drop_d  = in_drop_q;
        req_tgl_d  = req_tgl_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        if (in_valid_i && in_ready_q) begin
            a_d        = in_a_i;
            b_d        = in_b_i;
            mode_d     = mode_e'(mode_i);
            req_tgl_d  = ~req_tgl_q;
            in_ready_d = 1'b0;
        end else if (ack_sync != ack_dly_q) begin
            in_ready_d = 1'b1;
        end
        if (in_valid_i && !in_ready_q) begin
            in_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
            in_drop_q  <= 1'b0;
            req_tgl_q  <= 1'b0;
            ack_dly_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= ModeAdd;
        end else begin
            in_ready_q <= in_ready_d;
            in_drop_q  <= in_drop_d;
            req_tgl_q  <= req_tgl_d;
            ack_dly_q  <= ack_sync;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign in_drop_o  = in_drop_q;

    // ---------------- crossings ----------------
    logic req_sync, ack_tgl_q, ack_tgl_d;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i (clk_2),
        .rst_n (rst_n),
        .d_i   (req_tgl_q),
        .q_o   (req_sync)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i (clk_1),
        .rst_n (rst_n),
        .d_i   (ack_tgl_q),
        .q_o   (ack_sync)
    );

    // ---------------- destination domain (clk_2) ----------------
    dst_state_e       state_q, state_d;
    logic             req_dly_q;
    logic [OUT_W-1:0] out_q, out_d, result, a_ext, b_ext;

    // Hold regs are stable here: they only change after the ack has come back.
    always_comb begin
        a_ext = OUT_W'(a_q);
        b_ext = OUT_W'(b_q);
        case (mode_q)
            ModeAdd: result = a_ext + b_ext;
            ModeSub: result = a_ext - b_ext;
            ModeMul: result = a_ext * b_ext;
            default: result = (a_ext >= b_ext) ? a_ext : b_ext;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        ack_tgl_d   = ack_tgl_q;
        out_valid_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_sync != req_dly_q) begin
                    state_d = StComp;
                end
            end
            StComp: begin
                out_d   = result;
                state_d = StOut;
            end
            StOut: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    ack_tgl_d = ~ack_tgl_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        out_o = out_valid_o ? out_q : '0;
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_dly_q <= 1'b0;
            ack_tgl_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_dly_q <= req_sync;
            ack_tgl_q <= ack_tgl_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_cdc_arith_hs.sv
// Self-checking bench for cdc_arith_hs: directed cases plus randomized scoreboard runs.
`timescale 1ns/1ps
module tb_cdc_arith_hs;

    logic       clk_1 = 1'b0;
    logic       clk_2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [1:0] mode = '0;
    logic       in_ready, in_drop, out_valid;
    logic [7:0] out;

    real clk2_half = 8.5;
    int  errors = 0;
    int  checks = 0;

    always #5 clk_1 = ~clk_1;
    always #(clk2_half) clk_2 = ~clk_2;

    cdc_arith_hs #(.W(4), .SYNC_STAGES(2)) dut (
        .clk_1       (clk_1),
        .clk_2       (clk_2),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .mode_i      (mode),
        .in_drop_o   (in_drop),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out)
    );

    // Reference: unsigned operands, 8-bit result modulo 256.
    function automatic logic [7:0] model(input int a, input int b, input int m);
        int r;
        case (m)
            0:       r = a + b;
            1:       r = a - b + 256;
            2:       r = a * b;
            default: r = (a >= b) ? a : b;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic send(input int a, input int b, input int m);
        int n = 0;
        @(negedge clk_1);
        while (!in_ready && n < 200) begin
            @(negedge clk_1);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait_ready got=%b exp=1", in_ready);
        end
        in_a = 4'(a);
        in_b = 4'(b);
        mode = 2'(m);
        in_valid = 1'b1;
        @(negedge clk_1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++;
        if (in_drop !== 1'b0) begin errors++; $display("FAIL reset_in_drop got=%b exp=0", in_drop); end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk_2);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_no_fire out_valid=%b exp=0", out_valid);
            end
        end
    endtask

    task automatic test_arith();
        int         ta [4] = '{15, 3, 15, 9};
        int         tb [4] = '{15, 5, 15, 12};
        int         tm [4] = '{0, 1, 2, 3};
        logic [7:0] te [4] = '{8'h1E, 8'hFE, 8'hE1, 8'h0C};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int         pulses = 0;
            logic [7:0] got = '0;
            send(ta[i], tb[i], tm[i]);
            repeat (25) begin
                @(negedge clk_2);
                if (out_valid) begin
                    pulses++;
                    got = out;
                end
            end
            checks++;
            if (pulses != 1) begin errors++; $display("FAIL arith%0d_pulses got=%0d exp=1", i, pulses); end
            checks++;
            if (got !== te[i]) begin errors++; $display("FAIL arith%0d_out got=%h exp=%h", i, got, te[i]); end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL arith%0d_in_ready got=%b exp=1", i, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int         n = 0;
        int         pulses = 0;
        logic [7:0] o0;
        out_ready = 1'b0;
        send(7, 6, 2);
        while (!out_valid && n < 50) begin
            @(negedge clk_2);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        o0 = out;
        checks++;
        if (o0 !== model(7, 6, 2)) begin errors++; $display("FAIL bp_out got=%h exp=%h", o0, model(7, 6, 2)); end
        repeat (10) begin
            @(negedge clk_2);
            checks++;
            if (out_valid !== 1'b1 || out !== o0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold valid=%b out=%h in_ready=%b exp 1/%h/0", out_valid, out, in_ready, o0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk_2);
        out_ready = 1'b0;
        repeat (15) begin
            @(negedge clk_2);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL bp_extra_pulses got=%0d exp=0", pulses); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_drop();
        int         pulses = 0;
        logic [7:0] got = '0;
        checks++;
        if (in_drop !== 1'b0) begin errors++; $display("FAIL drop_initial got=%b exp=0", in_drop); end
        out_ready = 1'b0;
        send(2, 3, 0);
        in_a = 4'd9;
        in_b = 4'd9;
        mode = 2'd2;
        in_valid = 1'b1;
        @(negedge clk_1);
        in_valid = 1'b0;
        checks++;
        if (in_drop !== 1'b1) begin errors++; $display("FAIL drop_set got=%b exp=1", in_drop); end
        out_ready = 1'b1;
        repeat (30) begin
            @(negedge clk_2);
            if (out_valid) begin
                pulses++;
                got = out;
            end
        end
        out_ready = 1'b0;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
        checks++;
        if (got !== 8'h05) begin errors++; $display("FAIL drop_out got=%h exp=05", got); end
        checks++;
        if (in_ready !== 1'b1 || in_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_after in_ready=%b in_drop=%b exp 1/1", in_ready, in_drop);
        end
    endtask

    task automatic test_reset_mid_out();
        int n = 0;
        out_ready = 1'b0;
        send(5, 4, 3);
        while (!out_valid && n < 50) begin
            @(negedge clk_2);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h05) begin
            errors++;
            $display("FAIL mid_pre valid=%b out=%h exp 1/05", out_valid, out);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_drop !== 1'b0 || out_valid !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset in_ready=%b in_drop=%b valid=%b out=%h exp 1/0/0/00",
                     in_ready, in_drop, out_valid, out);
        end
        repeat (3) @(negedge clk_1);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk_2);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_release valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random(input real half, input int n);
        logic [7:0] q[$];
        int         pushed = 0;
        int         popped = 0;
        bit         abort = 1'b0;
        rst_n = 1'b0;
        clk2_half = half;
        repeat (6) @(negedge clk_1);
        rst_n = 1'b1;
        fork
            begin
                while (pushed < n && !abort) begin
                    @(negedge clk_1);
                    if (in_ready) begin
                        int a = $urandom_range(0, 15);
                        int b = $urandom_range(0, 15);
                        int m = $urandom_range(0, 3);
                        in_a = 4'(a);
                        in_b = 4'(b);
                        mode = 2'(m);
                        in_valid = 1'b1;
                        q.push_back(model(a, b, m));
                        pushed++;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk_1);
                in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (popped < n && cyc < n * 80) begin
                    logic ov;
                    @(negedge clk_2);
                    cyc++;
                    ov = out_valid;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (!ov) begin
                        checks++;
                        if (out !== 8'h00) begin errors++; $display("FAIL rand_idle_out got=%h exp=00", out); end
                    end else if (out_ready) begin
                        logic [7:0] e;
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_unexpected got=%h exp=none", out);
                        end else begin
                            e = q.pop_front();
                            if (out !== e) begin
                                errors++;
                                $display("FAIL rand_out idx=%0d got=%h exp=%h", popped, out, e);
                            end
                        end
                        popped++;
                    end
                end
                out_ready = 1'b0;
                checks++;
                if (popped != n) begin
                    errors++;
                    $display("FAIL rand_timeout popped=%0d exp=%0d", popped, n);
                end
                abort = 1'b1;
            end
        join
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_drop();
        test_reset_mid_out();
        test_random(8.5, 100);
        test_random(1.5, 200);
        test_random(23.5, 200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
